fetch_line_unpack: RTL and testbench
====================================

Name: fetch_line_unpack

Overview:
- Sits between the instruction-cache response path and decode in the warp-scheduler pipeline.
- Accepts one fetched line: an aligned PC, NUM_FETCH instruction slots, and a per-slot valid mask, where bit i set means slot i is at or after the requested PC.
- Emits the valid slots one per cycle, lowest index first, each with its own PC, under valid/ready handshakes on both sides.
- It is the consumer end of the aligned-PC/slot-mask fetch interface.

Parameters:
- NUM_FETCH, 2, instruction slots per fetched line (power of two, 1..8); each slot is 4 bytes.
- INST_W, 32, width of one instruction slot.
- WID_W, 3, warp-id width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- flush_i  input  1  discard the buffered line and any pending output.
- in_valid_i  input  1  fetch line valid.
- in_ready_o  output  1  unit can accept a line this cycle.
- in_pc_aligned_i  input  32  line base PC, aligned to NUM_FETCH*4 bytes.
- in_mask_i  input  NUM_FETCH  slot valid mask.
- in_data_i  input  NUM_FETCH*INST_W  slot i occupies bits [i*INST_W +: INST_W].
- in_wid_i  input  WID_W  warp id of the line.
- out_valid_o  output  1  instruction valid.
- out_ready_i  input  1  decode accepts the instruction.
- out_inst_o  output  INST_W  instruction.
- out_pc_o  output  32  instruction PC.
- out_wid_o  output  WID_W  warp id.
- out_last_o  output  1  last valid slot of the current line.

Behaviour:
- Clock and reset: single clock domain (clk); rst is synchronous and active-high.
- Reset values: all registers clear. out_valid_o=0, out_inst_o=0, out_pc_o=0, out_wid_o=0, out_last_o=0, internal busy=0, remaining-mask=0. in_ready_o=0 while rst is high, and 1 in the first cycle after rst deasserts.
- States:
  - IDLE (busy=0).
  - DRAIN (busy=1; a line is buffered with a nonzero remaining mask).
- Input acceptance:
  - in_fire = in_valid_i & in_ready_o.
  - in_ready_o = ~rst & ~flush_i & (~busy | (out_valid_o & out_ready_i & out_last_o)). This allows back-to-back lines with no bubble.
- Capture on in_fire: register pc_aligned, data, wid and remaining-mask = in_mask_i.
  - If in_mask_i != 0: go to DRAIN. out_valid_o=1 in the next cycle (latency 1), presenting the lowest set slot.
  - If in_mask_i == 0: the line is dropped, state stays or returns to IDLE, no output is produced, and in_ready_o=1 in the next cycle.
- Output for presented slot i:
  - out_inst_o = data slot i.
  - out_pc_o = pc_aligned + 4*i, 32-bit wrap-around, no overflow flag.
  - out_wid_o = captured wid.
  - out_last_o = 1 iff no set mask bit above i.
- Output hold: while out_valid_o & ~out_ready_i, all out_* signals stay stable.
- Output fire (out_valid_o & out_ready_i):
  - Clear bit i in remaining-mask.
  - If out_last_o is set: go to IDLE, unless in_fire occurs in the same cycle, in which case capture the new line and present its first slot next cycle.
  - Otherwise present the next set slot next cycle.
- Slot ordering: cleared mask bits between set bits are skipped with no idle cycle.
- Flush (flush_i=1), highest priority:
  - Next cycle busy=0, out_valid_o=0, remaining-mask=0.
  - in_ready_o=0 during the flush cycle; an in_valid_i presented in that cycle is not accepted.
  - Any output handshake in the flush cycle still completes, so decode may take that instruction.
- Reset mid-drain: the buffered line is discarded and no output follows.
- Input stability: in_* signals may change freely when in_ready_o=0. The unit never samples them then.

Test Plan:
- Partial line: NUM_FETCH=2, line pc_aligned=24, mask=2'b10, data={B,A}, wid=3. Response: one cycle later a single output inst=B, pc=28, wid=3, last=1; then IDLE.
- Full line: pc_aligned=0x100, mask=2'b11. Response: two outputs on consecutive cycles, (A, 0x100, last=0) then (B, 0x104, last=1).
- Backpressure: out_ready_i=0 for 3 cycles with mask=2'b11. Response: first output held stable for 3 cycles, in_ready_o=0 throughout; drain resumes when ready rises.
- Gap skip and back-to-back: NUM_FETCH=4, line1 pc=0x40 mask=4'b1010, line2 pc=0x50 mask=4'b0001 presented continuously. Response: PCs 0x44, 0x4C(last), 0x50(last) on 3 consecutive cycles with no bubble.
- Zero mask: mask=0 accepted. Response: no out_valid_o, in_ready_o=1 the next cycle.
- Flush mid-drain: NUM_FETCH=4, mask=4'b1111, flush_i pulsed after the first output fires. Response: out_valid_o=0 the next cycle, in_ready_o=0 in the flush cycle and 1 after; no PC from the flushed line appears again.

Source files
------------

// File: rtl/fetch_line_if.sv
// Fetch-line handshake bundle: an aligned-PC/slot-mask line toward the unpacker,
// and a per-instruction valid/ready stream toward decode.
interface fetch_line_if #(
    parameter int NUM_FETCH = 2,
    parameter int INST_W    = 32,
    parameter int WID_W     = 3
);
    logic                        flush_i;
    logic                        in_valid_i;
    logic                        in_ready_o;
    logic [31:0]                 in_pc_aligned_i;
    logic [NUM_FETCH-1:0]        in_mask_i;
    logic [NUM_FETCH*INST_W-1:0] in_data_i;
    logic [WID_W-1:0]            in_wid_i;
    logic                        out_valid_o;
    logic                        out_ready_i;
    logic [INST_W-1:0]           out_inst_o;
    logic [31:0]                 out_pc_o;
    logic [WID_W-1:0]            out_wid_o;
    logic                        out_last_o;

    modport slave (
        input  flush_i, in_valid_i, in_pc_aligned_i, in_mask_i, in_data_i, in_wid_i,
        input  out_ready_i,
        output in_ready_o, out_valid_o, out_inst_o, out_pc_o, out_wid_o, out_last_o
    );

    modport master (
        output flush_i, in_valid_i, in_pc_aligned_i, in_mask_i, in_data_i, in_wid_i,
        output out_ready_i,
        input  in_ready_o, out_valid_o, out_inst_o, out_pc_o, out_wid_o, out_last_o
    );
endinterface

// File: rtl/fetch_line_unpack.sv
// Buffers one fetched line and streams its valid slots to decode, lowest slot
// first, one per cycle, each tagged with its own PC and the line's warp id.
module fetch_line_unpack #(
    parameter int NUM_FETCH = 2,
    parameter int INST_W    = 32,
    parameter int WID_W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    fetch_line_if.slave  bus
);
    localparam int IDX_W = (NUM_FETCH > 1) ? $clog2(NUM_FETCH) : 1;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                      state_q, state_d;
    logic [NUM_FETCH-1:0]        rem_q, rem_d;
    logic [31:0]                 pc_q;
    logic [NUM_FETCH*INST_W-1:0] data_q;
    logic [WID_W-1:0]            wid_q;

    logic                        busy;
    logic                        in_ready;
    logic                        in_fire;
    logic                        out_fire;
    logic                        last;
    logic [IDX_W-1:0]            idx;
    logic [NUM_FETCH-1:0]        rem_after;
    logic [INST_W-1:0]           slot_inst;

    assign busy = (state_q == DRAIN);

    // Lowest remaining slot; popping it leaves rem_after, empty means this is the last one.
    always_comb begin
        idx       = '0;
        slot_inst = '0;
        for (int k = NUM_FETCH - 1; k >= 0; k--) begin
            if (rem_q[k]) idx = IDX_W'(k);
        end
        for (int k = 0; k < NUM_FETCH; k++) begin
            if (idx == IDX_W'(k)) slot_inst = data_q[k*INST_W +: INST_W];
        end
    end

    assign rem_after = rem_q & (rem_q - NUM_FETCH'(1));
    assign last      = (rem_after == '0);

    // Accepting on the cycle the last slot leaves keeps back-to-back lines bubble-free.
    assign in_ready = ~rst & ~bus.flush_i & (~busy | (bus.out_ready_i & last));
    assign in_fire  = bus.in_valid_i & in_ready;
    assign out_fire = busy & bus.out_ready_i;

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = busy;
    assign bus.out_inst_o  = busy ? slot_inst : '0;
    assign bus.out_pc_o    = busy ? (pc_q + (32'(idx) << 2)) : 32'd0;
    assign bus.out_wid_o   = busy ? wid_q : '0;
    assign bus.out_last_o  = busy & last;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (bus.flush_i) begin
            state_d = IDLE;
            rem_d   = '0;
        end else if (in_fire) begin
            rem_d   = bus.in_mask_i;
            state_d = (bus.in_mask_i != '0) ? DRAIN : IDLE;
        end else if (out_fire) begin
            rem_d   = rem_after;
            state_d = last ? IDLE : DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            pc_q    <= '0;
            data_q  <= '0;
            wid_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (in_fire) begin
                pc_q   <= bus.in_pc_aligned_i;
                data_q <= bus.in_data_i;
                wid_q  <= bus.in_wid_i;
            end
        end
    end
endmodule

// File: tb/tb_fetch_line_unpack.sv
// Directed bench for fetch_line_unpack with four slots per line: a table of single
// lines plus hand-written stall, back-to-back, zero-mask, flush and reset sequences.
module tb_fetch_line_unpack;
    localparam int NF = 4;
    localparam int IW = 32;
    localparam int WW = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetch_line_if #(.NUM_FETCH(NF), .INST_W(IW), .WID_W(WW)) bus ();

    fetch_line_unpack #(.NUM_FETCH(NF), .INST_W(IW), .WID_W(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0]      pc;
        logic [3:0]       mask;
        logic [2:0]       wid;
        logic [2:0]       n;
        logic [3:0][31:0] epc;
        logic [3:0][1:0]  eidx;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mkv(input logic [31:0] pc, input logic [3:0] mask,
                                 input logic [2:0] wid, input int n,
                                 input logic [31:0] p0, input logic [31:0] p1,
                                 input logic [31:0] p2, input logic [31:0] p3,
                                 input int x0, input int x1, input int x2, input int x3);
        vec_t v;
        v.pc = pc; v.mask = mask; v.wid = wid; v.n = 3'(n);
        v.epc[0] = p0; v.epc[1] = p1; v.epc[2] = p2; v.epc[3] = p3;
        v.eidx[0] = 2'(x0); v.eidx[1] = 2'(x1); v.eidx[2] = 2'(x2); v.eidx[3] = 2'(x3);
        return v;
    endfunction

    function automatic logic [31:0] mkslot(input logic [7:0] tag, input int k);
        return {tag, 16'h5A00, 8'(k)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_line(input logic [31:0] pc, input logic [3:0] mask,
                              input logic [2:0] wid, input logic [7:0] tag);
        bus.in_pc_aligned_i = pc;
        bus.in_mask_i       = mask;
        bus.in_wid_i        = wid;
        for (int k = 0; k < NF; k++) bus.in_data_i[k*IW +: IW] = mkslot(tag, k);
        bus.in_valid_i = 1'b1;
    endtask

    task automatic chk_out(input string name, input logic [31:0] pc, input logic [7:0] tag,
                           input int slot, input logic [2:0] wid, input logic last);
        chk({name, "_valid"}, 32'(bus.out_valid_o), 32'd1);
        chk({name, "_pc"},    bus.out_pc_o, pc);
        chk({name, "_inst"},  bus.out_inst_o, mkslot(tag, slot));
        chk({name, "_wid"},   32'(bus.out_wid_o), 32'(wid));
        chk({name, "_last"},  32'(bus.out_last_o), 32'(last));
    endtask

    initial begin
        vecs[0] = mkv(32'h20,       4'b0010, 3'd3, 1, 32'h24, 0, 0, 0, 1, 0, 0, 0);
        vecs[1] = mkv(32'h100,      4'b0011, 3'd1, 2, 32'h100, 32'h104, 0, 0, 0, 1, 0, 0);
        vecs[2] = mkv(32'h40,       4'b1010, 3'd2, 2, 32'h44, 32'h4C, 0, 0, 1, 3, 0, 0);
        vecs[3] = mkv(32'h50,       4'b0001, 3'd5, 1, 32'h50, 0, 0, 0, 0, 0, 0, 0);
        vecs[4] = mkv(32'hFFFFFFF0, 4'b1100, 3'd7, 2, 32'hFFFFFFF8, 32'hFFFFFFFC, 0, 0, 2, 3, 0, 0);
        vecs[5] = mkv(32'h200,      4'b1111, 3'd0, 4, 32'h200, 32'h204, 32'h208, 32'h20C, 0, 1, 2, 3);
        vecs[6] = mkv(32'h300,      4'b1001, 3'd4, 2, 32'h300, 32'h30C, 0, 0, 0, 3, 0, 0);

        rst = 1'b1;
        bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
        bus.in_pc_aligned_i = '0; bus.in_mask_i = '0; bus.in_data_i = '0; bus.in_wid_i = '0;

        // Reset state, with a line offered that must not be taken.
        repeat (2) @(negedge clk);
        drive_line(32'h80, 4'b1111, 3'd6, 8'hEE);
        #1;
        chk("rst_in_ready",  32'(bus.in_ready_o), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_out_pc",    bus.out_pc_o, 32'd0);
        chk("rst_out_inst",  bus.out_inst_o, 32'd0);
        chk("rst_out_last",  32'(bus.out_last_o), 32'd0);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        chk("post_rst_out_valid", 32'(bus.out_valid_o), 32'd0);

        // Table: one line each, decode always ready.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive_line(vecs[i].pc, vecs[i].mask, vecs[i].wid, 8'(8'h10 + i));
            bus.out_ready_i = 1'b1;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready_o), 32'd1);
            @(negedge clk);
            bus.in_valid_i = 1'b0;
            #1;
            for (int j = 0; j < int'(vecs[i].n); j++) begin
                chk_out($sformatf("v%0d_o%0d", i, j), vecs[i].epc[j], 8'(8'h10 + i),
                        int'(vecs[i].eidx[j]), vecs[i].wid, j == int'(vecs[i].n) - 1);
                @(negedge clk);
                #1;
            end
            chk($sformatf("v%0d_done_valid", i), 32'(bus.out_valid_o), 32'd0);
        end

        // Backpressure: first slot held for 3 cycles, a pending line is refused.
        @(negedge clk);
        drive_line(32'h100, 4'b0011, 3'd2, 8'h80);
        bus.out_ready_i = 1'b0;
        @(negedge clk);
        drive_line(32'h400, 4'b1111, 3'd1, 8'h81);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk_out($sformatf("bp_hold%0d", c), 32'h100, 8'h80, 0, 3'd2, 1'b0);
            chk($sformatf("bp_in_ready%0d", c), 32'(bus.in_ready_o), 32'd0);
            @(negedge clk);
            #1;
        end
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        #1;
        chk_out("bp_release", 32'h100, 8'h80, 0, 3'd2, 1'b0);
        @(negedge clk); #1;
        chk_out("bp_second", 32'h104, 8'h80, 1, 3'd2, 1'b1);
        @(negedge clk); #1;
        chk("bp_done_valid", 32'(bus.out_valid_o), 32'd0);

        // Gap skip and back-to-back lines with no bubble.
        @(negedge clk);
        drive_line(32'h40, 4'b1010, 3'd2, 8'h90);
        @(negedge clk);
        drive_line(32'h50, 4'b0001, 3'd5, 8'h91);
        #1;
        chk_out("b2b_0", 32'h44, 8'h90, 1, 3'd2, 1'b0);
        chk("b2b_0_in_ready", 32'(bus.in_ready_o), 32'd0);
        @(negedge clk); #1;
        chk_out("b2b_1", 32'h4C, 8'h90, 3, 3'd2, 1'b1);
        chk("b2b_1_in_ready", 32'(bus.in_ready_o), 32'd1);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1;
        chk_out("b2b_2", 32'h50, 8'h91, 0, 3'd5, 1'b1);
        @(negedge clk); #1;
        chk("b2b_done_valid", 32'(bus.out_valid_o), 32'd0);

        // Zero mask is accepted and produces nothing.
        @(negedge clk);
        drive_line(32'h600, 4'b0000, 3'd1, 8'hB0);
        #1;
        chk("zm_in_ready", 32'(bus.in_ready_o), 32'd1);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1;
        chk("zm_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("zm_in_ready_next", 32'(bus.in_ready_o), 32'd1);
        @(negedge clk); #1;
        chk("zm_out_valid2", 32'(bus.out_valid_o), 32'd0);

        // Flush after the first slot fires; a line offered in the flush cycle is refused.
        @(negedge clk);
        drive_line(32'h200, 4'b1111, 3'd3, 8'hA0);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1;
        chk_out("fl_first", 32'h200, 8'hA0, 0, 3'd3, 1'b0);
        @(negedge clk);
        bus.flush_i = 1'b1;
        drive_line(32'h500, 4'b1111, 3'd4, 8'hA1);
        #1;
        chk_out("fl_cycle", 32'h204, 8'hA0, 1, 3'd3, 1'b0);
        chk("fl_in_ready", 32'(bus.in_ready_o), 32'd0);
        @(negedge clk);
        bus.flush_i = 1'b0;
        bus.in_valid_i = 1'b0;
        #1;
        chk("fl_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("fl_in_ready_after", 32'(bus.in_ready_o), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk($sformatf("fl_quiet%0d", c), 32'(bus.out_valid_o), 32'd0);
        end

        // Reset in the middle of a drain discards the line.
        @(negedge clk);
        drive_line(32'h300, 4'b1111, 3'd6, 8'hC0);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1;
        chk_out("rd_first", 32'h300, 8'hC0, 0, 3'd6, 1'b0);
        rst = 1'b1;
        #1;
        chk("rd_in_ready", 32'(bus.in_ready_o), 32'd0);
        @(negedge clk); #1;
        chk("rd_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rd_out_pc", bus.out_pc_o, 32'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("rd_out_valid2", 32'(bus.out_valid_o), 32'd0);
        chk("rd_in_ready2", 32'(bus.in_ready_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
